// File: rtl/speaker_gain_pkg.sv
// Shared types and helpers for the speaker gain ramp scheduler.
package speaker_gain_pkg;

  localparam int unsigned GAIN_W_DEF = 16;
  localparam int unsigned MAX_CH     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Extracts channel k from a packed gain bus of up to MAX_CH default-width words.
  function automatic logic [GAIN_W_DEF-1:0] gain_slice(
    input logic [GAIN_W_DEF*MAX_CH-1:0] bus,
    input int unsigned                  k
  );
    return bus[k*GAIN_W_DEF +: GAIN_W_DEF];
  endfunction

endpackage

// File: rtl/speaker_gain_ramp_ctrl_gain_step_unit.sv
// Combinational bounded step of one gain word toward its effective target.
module gain_step_unit #(
  parameter int unsigned GAIN_W = 16
) (
  input  logic [GAIN_W-1:0] cur_i,
  input  logic [GAIN_W-1:0] eff_i,
  input  logic [GAIN_W-1:0] step_i,
  output logic [GAIN_W-1:0] next_o
);

  logic [GAIN_W-1:0] diff;

  // The distance is compared against step before adding, so no wrap can occur.
  always_comb begin
    next_o = cur_i;
    diff   = '0;
    if (eff_i > cur_i) begin
      diff   = eff_i - cur_i;
      next_o = (diff <= step_i) ? eff_i : cur_i + step_i;
    end else if (eff_i < cur_i) begin
      diff   = cur_i - eff_i;
      next_o = (diff <= step_i) ? eff_i : cur_i - step_i;
    end
  end

endmodule

// File: rtl/speaker_gain_ramp_ctrl.sv
// Per-channel gain ramp scheduler: one shared step unit visits every channel per sample tick.
module speaker_gain_ramp_ctrl
  import speaker_gain_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned GAIN_W = GAIN_W_DEF,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [GAIN_W-1:0]        cfg_gain,
  input  logic [GAIN_W-1:0]        step,
  input  logic                     mute,
  input  logic                     sample_tick,
  input  logic                     clr_overrun,
  output logic [NUM_CH*GAIN_W-1:0] gain_out,
  output logic                     gain_valid,
  output logic [NUM_CH-1:0]        settled,
  output logic                     busy,
  output logic                     overrun
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [GAIN_W-1:0] cur_q [NUM_CH];
  logic [GAIN_W-1:0] cur_d [NUM_CH];
  logic [GAIN_W-1:0] tgt_q [NUM_CH];
  logic [GAIN_W-1:0] tgt_d [NUM_CH];
  logic [NUM_CH-1:0] settled_q, settled_d;
  logic              overrun_q, overrun_d;

  logic [GAIN_W-1:0] cur_sel, eff_sel, next_sel;
  logic              cfg_fire;

  always_comb begin
    cur_sel = cur_q[ch_q];
    eff_sel = mute ? '0 : tgt_q[ch_q];
  end

  gain_step_unit #(
    .GAIN_W (GAIN_W)
  ) u_step (
    .cur_i  (cur_sel),
    .eff_i  (eff_sel),
    .step_i (step),
    .next_o (next_sel)
  );

  assign cfg_ready  = (state_q != SCAN);
  assign busy       = (state_q != IDLE);
  assign gain_valid = (state_q == DONE);
  assign settled    = settled_q;
  assign overrun    = overrun_q;
  assign cfg_fire   = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    overrun_d = overrun_q;
    settled_d = '0;

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SCAN;
          ch_d    = '0;
        end
      end
      SCAN: begin
        cur_d[ch_q] = next_sel;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = DONE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cfg_fire) begin
      tgt_d[cfg_ch] = cfg_gain;
    end

    // Clear first so a coincident late tick wins.
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      settled_d[k] = (cur_d[k] == (mute ? '0 : tgt_d[k]));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      settled_q <= '1;
      overrun_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cur_q[k] <= '0;
        tgt_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      settled_q <= settled_d;
      overrun_q <= overrun_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
    end
  end

  always_comb begin
    gain_out = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      gain_out[k*GAIN_W +: GAIN_W] = cur_q[k];
    end
  end

endmodule

// File: tb/tb_speaker_gain_ramp_ctrl.sv
// Directed self-checking bench for speaker_gain_ramp_ctrl with four 16-bit channels.
module tb_speaker_gain_ramp_ctrl;
  import speaker_gain_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned GAIN_W = 16;

  logic                     ACLK;
  logic                     ARESETN;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [1:0]               cfg_ch;
  logic [GAIN_W-1:0]        cfg_gain;
  logic [GAIN_W-1:0]        step;
  logic                     mute;
  logic                     sample_tick;
  logic                     clr_overrun;
  logic [NUM_CH*GAIN_W-1:0] gain_out;
  logic                     gain_valid;
  logic [NUM_CH-1:0]        settled;
  logic                     busy;
  logic                     overrun;

  int tests = 0;
  int fails = 0;

  speaker_gain_ramp_ctrl #(
    .NUM_CH (NUM_CH),
    .GAIN_W (GAIN_W)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_gain    (cfg_gain),
    .step        (step),
    .mute        (mute),
    .sample_tick (sample_tick),
    .clr_overrun (clr_overrun),
    .gain_out    (gain_out),
    .gain_valid  (gain_valid),
    .settled     (settled),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  task automatic step_clk();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GAIN_W-1:0] ch_gain(input int unsigned k);
    return gain_slice((GAIN_W_DEF*MAX_CH)'(gain_out), k);
  endfunction

  task automatic cfg_write(input logic [1:0] ch, input logic [GAIN_W-1:0] g);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_gain  = g;
    step_clk();
    cfg_valid = 1'b0;
  endtask

  // Pulses sample_tick for one cycle and stops in the DONE cycle.
  task automatic run_scan(input string tag);
    int n;
    n = 0;
    sample_tick = 1'b1;
    do begin
      step_clk();
      sample_tick = 1'b0;
      n++;
    end while (gain_valid !== 1'b1 && n < 12);
    chk({tag, "_latency"}, 64'(n), 64'd5);
  endtask

  task automatic finish_scan(input string tag);
    step_clk();
    chk({tag, "_valid_drop"}, 64'(gain_valid), 64'd0);
  endtask

  initial begin
    int cnt;
    ARESETN     = 1'b0;
    cfg_valid   = 1'b0;
    cfg_ch      = '0;
    cfg_gain    = '0;
    step        = '0;
    mute        = 1'b0;
    sample_tick = 1'b0;
    clr_overrun = 1'b0;
    step_clk();
    step_clk();
    ARESETN = 1'b1;
    step_clk();

    chk("rst_gain",    64'(gain_out),   64'h0);
    chk("rst_settled", 64'(settled),    64'hF);
    chk("rst_ready",   64'(cfg_ready),  64'd1);
    chk("rst_busy",    64'(busy),       64'd0);
    chk("rst_valid",   64'(gain_valid), 64'd0);
    chk("rst_overrun", 64'(overrun),    64'd0);

    // Up-ramp on channel 2
    step = 16'h0040;
    cfg_write(2'd2, 16'h0100);
    chk("ramp_settled_pre", 64'(settled), 64'hB);
    for (int i = 1; i <= 4; i++) begin
      run_scan("ramp");
      chk("ramp_busy_done", 64'(busy), 64'd1);
      chk("ramp_gain", 64'(gain_out), 64'(i * 16'h0040) << 32);
      chk("ramp_settled2", 64'(settled[2]), 64'(i == 4));
      finish_scan("ramp");
    end
    chk("ramp_idle_busy", 64'(busy), 64'd0);

    // Clamp on channel 0
    cfg_write(2'd0, 16'h0050);
    run_scan("clamp1");
    chk("clamp1_ch0", 64'(ch_gain(0)), 64'h0040);
    finish_scan("clamp1");
    run_scan("clamp2");
    chk("clamp2_ch0", 64'(ch_gain(0)), 64'h0050);
    chk("clamp2_ch2", 64'(ch_gain(2)), 64'h0100);
    finish_scan("clamp2");
    run_scan("clamp3");
    chk("clamp3_ch0", 64'(ch_gain(0)), 64'h0050);
    chk("clamp3_settled", 64'(settled), 64'hF);
    finish_scan("clamp3");

    // Mute down-ramp and recovery on channel 1
    step = 16'h0080;
    cfg_write(2'd1, 16'h0100);
    run_scan("m_up1");
    finish_scan("m_up1");
    run_scan("m_up2");
    chk("m_up_ch1", 64'(ch_gain(1)), 64'h0100);
    finish_scan("m_up2");
    mute = 1'b1;
    run_scan("mute1");
    chk("mute1_ch1", 64'(ch_gain(1)), 64'h0080);
    finish_scan("mute1");
    run_scan("mute2");
    chk("mute2_gain", 64'(gain_out), 64'h0);
    chk("mute2_settled", 64'(settled), 64'hF);
    finish_scan("mute2");
    mute = 1'b0;
    step_clk();
    chk("unmute_settled", 64'(settled), 64'h8);
    run_scan("unmute1");
    chk("unmute1_gain", 64'(gain_out), 64'h0000_0080_0080_0050);
    chk("unmute1_settled", 64'(settled), 64'h9);
    finish_scan("unmute1");
    run_scan("unmute2");
    chk("unmute2_gain", 64'(gain_out), 64'h0000_0100_0100_0050);
    chk("unmute2_settled", 64'(settled), 64'hF);
    finish_scan("unmute2");

    // Overrun: second tick two cycles into a scan
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    step_clk();
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      if (gain_valid === 1'b1) cnt++;
    end
    chk("ovr_one_valid", 64'(cnt), 64'd1);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    clr_overrun = 1'b1;
    step_clk();
    clr_overrun = 1'b0;
    chk("ovr_clear", 64'(overrun), 64'd0);
    sample_tick = 1'b1;
    step_clk();
    clr_overrun = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    for (int i = 0; i < 8; i++) step_clk();
    chk("ovr_back_idle", 64'(busy), 64'd0);

    // Handshake: write held through a scan lands in DONE
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_gain  = 16'h0040;
    cnt = 0;
    while (cfg_ready !== 1'b1 && cnt < 20) begin
      cnt++;
      step_clk();
    end
    chk("hs_stall_cycles", 64'(cnt), 64'd4);
    chk("hs_in_done", 64'(gain_valid), 64'd1);
    step_clk();
    cfg_valid = 1'b0;
    chk("hs_ch3_gain", 64'(ch_gain(3)), 64'h0);
    chk("hs_settled", 64'(settled), 64'h7);

    // Write coincident with tick: scan uses the new target
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_gain  = 16'h0100;
    sample_tick = 1'b1;
    step_clk();
    cfg_valid   = 1'b0;
    sample_tick = 1'b0;
    cnt = 1;
    while (gain_valid !== 1'b1 && cnt < 12) begin
      step_clk();
      cnt++;
    end
    chk("coinc_latency", 64'(cnt), 64'd5);
    chk("coinc_ch3", 64'(ch_gain(3)), 64'h0080);
    finish_scan("coinc");

    // Asynchronous reset in the middle of a scan
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    step_clk();
    step_clk();
    chk("arst_pre_busy", 64'(busy), 64'd1);
    chk("arst_pre_gain", 64'(gain_out), 64'h0080_0100_0100_0050);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("arst_gain",    64'(gain_out),  64'h0);
    chk("arst_settled", 64'(settled),   64'hF);
    chk("arst_ready",   64'(cfg_ready), 64'd1);
    chk("arst_busy",    64'(busy),      64'd0);
    chk("arst_overrun", 64'(overrun),   64'd0);
    step_clk();
    ARESETN = 1'b1;
    step_clk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/speaker_gain_ramp_ctrl.md
Name: speaker_gain_ramp_ctrl

Overview:
- Per-channel gain ramp scheduler for the speaker line-array gain datapath.
- Software or an upstream config master writes target gains per speaker channel.
- On each audio sample tick, the block scans all channels time-multiplexed and moves each current gain one bounded step toward its target, which avoids zipper noise.
- The packed current gains drive the gain multipliers downstream.

Parameters:
- NUM_CH, 4: number of speaker channels (>=2)
- GAIN_W, 16: gain word width, unsigned
- CH_W, $clog2(NUM_CH): channel index width (derived, not overridden)

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- cfg_valid  in  1  target-gain write request
- cfg_ready  out  1  target write accepted when cfg_valid&&cfg_ready at posedge
- cfg_ch  in  CH_W  channel to write
- cfg_gain  in  GAIN_W  new target gain
- step  in  GAIN_W  ramp step magnitude per tick, unsigned
- mute  in  1  when 1, effective target of every channel is 0
- sample_tick  in  1  one-cycle pulse per audio sample
- clr_overrun  in  1  clears overrun
- gain_out  out  NUM_CH*GAIN_W  current gains; channel k at [k*GAIN_W +: GAIN_W]
- gain_valid  out  1  one-cycle pulse after a full scan
- settled  out  NUM_CH  bit k=1 when current[k]==effective target[k]
- busy  out  1  scan in progress
- overrun  out  1  sticky: sample_tick arrived while not IDLE

Behaviour:
- Reset values (async, any state):
  - cur[] and tgt[] are 0; state is IDLE; channel counter is 0.
  - gain_out=0, gain_valid=0, busy=0, overrun=0, cfg_ready=1, settled=all 1s.
- FSM states:
  - IDLE: on sample_tick, go to SCAN with ch=0.
  - SCAN: processes channel ch in this cycle; registered update at the edge. If ch==NUM_CH-1, go to DONE; else ch+1.
  - DONE: gain_valid=1 for exactly this cycle; go to IDLE.
- Latency: tick sampled at edge E. Channel k is updated at edge E+1+k. gain_valid is high in the cycle after edge E+NUM_CH, so a scan takes NUM_CH+2 cycles tick-to-IDLE.
- Step rule, with eff = mute ? 0 : tgt[ch]:
  - eff>cur and (eff-cur)<=step: cur=eff.
  - eff>cur otherwise: cur+step.
  - eff<cur is symmetric (subtract, clamp at eff).
  - Equal values, or step==0: hold.
  - No wrap is possible; intermediate differences are computed at GAIN_W bits.
- Mute is sampled per channel in that channel's SCAN cycle; tgt[] is not modified by mute.
- gain_out and settled are registered directly from cur[] and tgt[]/mute and update as each channel is written.
- cfg_ready=1 in IDLE and DONE, 0 in SCAN. A cfg write in the same IDLE cycle as sample_tick lands at the same edge as the IDLE->SCAN transition, so the scan uses the new target.
- Overrun:
  - sample_tick outside IDLE is ignored and sets overrun.
  - clr_overrun clears it; set wins when both occur in the same cycle.
- busy=1 in SCAN and DONE.
- Out-of-range cfg_ch (>=NUM_CH when NUM_CH is not a power of 2) is accepted and discarded.

Decomposition:
- Package speaker_gain_pkg holds:
  - state enum (IDLE, SCAN, DONE)
  - default GAIN_W
  - a function for gain slice extraction
- Sub-module gain_step_unit: combinational next-gain computation (cur, eff, step -> next). It is instantiated once and shared across channels by the scan.

Test Plan:
1. Assert ARESETN=0 mid-operation -> gain_out=0, settled=4'b1111, cfg_ready=1, busy=0 immediately, without a clock edge.
2. Write ch2 target 0x0100, step=0x0040, then 4 ticks -> ch2 reads 0x0040, 0x0080, 0x00C0, 0x0100 at successive gain_valid pulses. settled[2] is 0 until the 4th scan. Other channels stay 0. gain_valid comes 5 cycles after each tick.
3. Clamp: ch0 target 0x0050, step=0x0040, 2 ticks -> ch0 reads 0x0040, then 0x0050 (no overshoot). A third tick holds at 0x0050.
4. Mute/down-ramp: ch1 settled at 0x0100, step=0x0080, mute=1 -> 0x0080 then 0x0000. mute=0 -> 0x0080 then 0x0100, with tgt[1] unchanged.
5. Overrun: tick at cycle 0 and again at cycle 2 -> one gain_valid only, overrun=1. Pulsing clr_overrun -> overrun=0. clr_overrun asserted in the same cycle as a new overrun -> overrun stays 1.
6. Handshake: cfg_valid asserted at SCAN entry -> cfg_ready=0 for NUM_CH cycles, write accepted in the DONE cycle. A write coincident with a tick in IDLE -> that scan already ramps toward the new target.
